// File: rtl/act_pingpong_ctrl.sv
// rtl/act_pingpong_ctrl.sv - ping-pong activation buffer controller between a frame writer and a PE reader
// Two BRAM banks alternate: the writer fills one while the PE consumes the other.

module act_pingpong_ctrl #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,

    input  logic [AWIDTH-1:0] wr_addr,
    input  logic              wr_ce,
    input  logic              wr_we,
    input  logic [DWIDTH-1:0] wr_d,
    input  logic              wr_done,
    output logic              wr_ready,

    input  logic [AWIDTH-1:0] rd_addr,
    input  logic              rd_ce,
    output logic [DWIDTH-1:0] rd_q,
    input  logic              rd_done,

    output logic              SyncSig_V,
    output logic              SyncSig_V_ap_vld,
    input  logic              SyncSig_V_ap_ack,

    output logic [AWIDTH:0]   bram_addr1,
    output logic              bram_ce1,
    output logic              bram_we1,
    output logic [DWIDTH-1:0] bram_d1,

    output logic [AWIDTH:0]   bram_addr0,
    output logic              bram_ce0,
    input  logic [DWIDTH-1:0] bram_q0,

    output logic [7:0]        blocked_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_full;
    logic [1:0]  w_full_nxt;
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic [7:0]  r_blocked_cnt;

    logic        w_wr_ready;
    logic        w_wr_commit;
    logic        w_rd_release;
    logic        w_blocked;

    // Writer side: accesses pass through only while its bank is empty.
    assign w_wr_ready  = ~r_full[r_wr_bank];
    assign w_wr_commit = wr_done & w_wr_ready;
    assign w_blocked   = wr_ce & ~w_wr_ready;

    assign wr_ready    = w_wr_ready;
    assign bram_addr1  = {r_wr_bank, wr_addr};
    assign bram_d1     = wr_d;
    assign bram_ce1    = wr_ce & w_wr_ready;
    assign bram_we1    = wr_we & w_wr_ready;

    assign bram_addr0  = {r_rd_bank, rd_addr};
    assign rd_q        = bram_q0;
    assign SyncSig_V   = r_rd_bank;
    assign blocked_cnt = r_blocked_cnt;

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_release     = 1'b0;
        SyncSig_V_ap_vld = 1'b0;
        bram_ce0         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                SyncSig_V_ap_vld = 1'b1;
                if (SyncSig_V_ap_ack) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                bram_ce0 = rd_ce;
                if (rd_done) begin
                    w_rd_release = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Commit and release never hit the same bank, so both may apply in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_commit) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= S_IDLE;
            r_full        <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_blocked_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            if (w_wr_commit) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_rd_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_blocked && (r_blocked_cnt != 8'hFF)) begin
                r_blocked_cnt <= r_blocked_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_act_pingpong_ctrl.sv
// tb/tb_act_pingpong_ctrl.sv - directed self-checking bench for act_pingpong_ctrl

module tb_act_pingpong_ctrl;

    localparam int AWIDTH = 12;
    localparam int DWIDTH = 16;

    logic              ap_clk;
    logic              ap_rst_n;
    logic [AWIDTH-1:0] wr_addr;
    logic              wr_ce;
    logic              wr_we;
    logic [DWIDTH-1:0] wr_d;
    logic              wr_done;
    logic              wr_ready;
    logic [AWIDTH-1:0] rd_addr;
    logic              rd_ce;
    logic [DWIDTH-1:0] rd_q;
    logic              rd_done;
    logic              SyncSig_V;
    logic              SyncSig_V_ap_vld;
    logic              SyncSig_V_ap_ack;
    logic [AWIDTH:0]   bram_addr1;
    logic              bram_ce1;
    logic              bram_we1;
    logic [DWIDTH-1:0] bram_d1;
    logic [AWIDTH:0]   bram_addr0;
    logic              bram_ce0;
    logic [DWIDTH-1:0] bram_q0;
    logic [7:0]        blocked_cnt;

    int n_cmp;
    int n_fail;

    act_pingpong_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .wr_addr          (wr_addr),
        .wr_ce            (wr_ce),
        .wr_we            (wr_we),
        .wr_d             (wr_d),
        .wr_done          (wr_done),
        .wr_ready         (wr_ready),
        .rd_addr          (rd_addr),
        .rd_ce            (rd_ce),
        .rd_q             (rd_q),
        .rd_done          (rd_done),
        .SyncSig_V        (SyncSig_V),
        .SyncSig_V_ap_vld (SyncSig_V_ap_vld),
        .SyncSig_V_ap_ack (SyncSig_V_ap_ack),
        .bram_addr1       (bram_addr1),
        .bram_ce1         (bram_ce1),
        .bram_we1         (bram_we1),
        .bram_d1          (bram_d1),
        .bram_addr0       (bram_addr0),
        .bram_ce0         (bram_ce0),
        .bram_q0          (bram_q0),
        .blocked_cnt      (blocked_cnt)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_addr = '0; wr_ce = 0; wr_we = 0; wr_d = '0; wr_done = 0;
        rd_addr = '0; rd_ce = 0; rd_done = 0; SyncSig_V_ap_ack = 0; bram_q0 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 ap_rst_n = 0;
        #3;
        tick();
        ap_rst_n = 1;
        tick();
    endtask

    task automatic write_frame(input int n);
        for (int i = 0; i < n; i++) begin
            wr_ce = 1; wr_we = 1; wr_addr = AWIDTH'(i); wr_d = DWIDTH'(16'h0100 + i);
            tick();
        end
        wr_ce = 0; wr_we = 0; wr_done = 1;
        tick();
        wr_done = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %0b exp 1", wr_ready); end
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b exp 0", SyncSig_V_ap_vld); end
        n_cmp++; if (SyncSig_V !== 1'b0) begin n_fail++; $display("FAIL reset_sync got %0b exp 0", SyncSig_V); end
        rd_ce = 1;
        #1;
        n_cmp++; if (bram_ce0 !== 1'b0) begin n_fail++; $display("FAIL reset_ce0 got %0b exp 0", bram_ce0); end
        n_cmp++; if (blocked_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_blocked got %0d exp 0", blocked_cnt); end
        rd_ce = 0;
    endtask

    task automatic test_write_frame();
        logic [AWIDTH:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            wr_ce = 1; wr_we = 1; wr_addr = AWIDTH'(i); wr_d = DWIDTH'(16'hA000 + i);
            #1;
            exp_a = (AWIDTH+1)'(i);
            n_cmp++; if (bram_addr1 !== exp_a || bram_ce1 !== 1'b1 || bram_we1 !== 1'b1 || bram_d1 !== DWIDTH'(16'hA000 + i)) begin
                n_fail++; $display("FAIL wr_word%0d got a=%h ce=%b we=%b d=%h exp a=%h ce=1 we=1 d=%h", i, bram_addr1, bram_ce1, bram_we1, bram_d1, exp_a, 16'hA000 + i);
            end
            tick();
        end
        wr_ce = 0; wr_we = 0; wr_done = 1;
        tick();
        wr_done = 0; wr_addr = '0;
        #1;
        n_cmp++; if (bram_addr1 !== 13'h1000) begin n_fail++; $display("FAIL wr_bank_toggle got %h exp 1000", bram_addr1); end
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b0) begin n_fail++; $display("FAIL vld_idle_cycle got %0b exp 0", SyncSig_V_ap_vld); end
        tick();
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b1 || SyncSig_V !== 1'b0) begin
            n_fail++; $display("FAIL vld_latency got vld=%0b sync=%0b exp vld=1 sync=0", SyncSig_V_ap_vld, SyncSig_V);
        end
    endtask

    task automatic test_hold_ack();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (SyncSig_V_ap_vld !== 1'b1 || SyncSig_V !== 1'b0) begin
                n_fail++; $display("FAIL vld_hold%0d got vld=%0b sync=%0b exp vld=1 sync=0", c, SyncSig_V_ap_vld, SyncSig_V);
            end
        end
        rd_ce = 1; rd_addr = 12'd3; SyncSig_V_ap_ack = 1;
        #1;
        n_cmp++; if (bram_ce0 !== 1'b0) begin n_fail++; $display("FAIL ce0_in_sync got %0b exp 0", bram_ce0); end
        tick();
        SyncSig_V_ap_ack = 0; bram_q0 = 16'hBEEF;
        #1;
        n_cmp++; if (bram_addr0 !== 13'h003 || bram_ce0 !== 1'b1 || SyncSig_V_ap_vld !== 1'b0) begin
            n_fail++; $display("FAIL busy_read got a0=%h ce0=%b vld=%b exp a0=003 ce0=1 vld=0", bram_addr0, bram_ce0, SyncSig_V_ap_vld);
        end
        n_cmp++; if (rd_q !== 16'hBEEF) begin n_fail++; $display("FAIL rd_q got %h exp beef", rd_q); end
        rd_ce = 0; rd_addr = '0;
    endtask

    task automatic test_both_full();
        write_frame(3);
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL both_full_ready got %0b exp 0", wr_ready); end
        for (int p = 0; p < 3; p++) begin
            wr_ce = 1; wr_we = 1;
            #1;
            n_cmp++; if (bram_ce1 !== 1'b0 || bram_we1 !== 1'b0) begin
                n_fail++; $display("FAIL blocked_ce1_%0d got ce1=%b we1=%b exp 0 0", p, bram_ce1, bram_we1);
            end
            tick();
            wr_ce = 0; wr_we = 0;
            tick();
        end
        n_cmp++; if (blocked_cnt !== 8'd3) begin n_fail++; $display("FAIL blocked_cnt3 got %0d exp 3", blocked_cnt); end
        wr_done = 1;
        tick();
        wr_done = 0;
        rd_done = 1;
        tick();
        rd_done = 0;
        n_cmp++; if (wr_ready !== 1'b1 || bram_addr1[AWIDTH] !== 1'b0) begin
            n_fail++; $display("FAIL resume_bank0 got ready=%b bank=%b exp ready=1 bank=0", wr_ready, bram_addr1[AWIDTH]);
        end
        tick();
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b1 || SyncSig_V !== 1'b1) begin
            n_fail++; $display("FAIL sync_bank1 got vld=%b sync=%b exp 1 1", SyncSig_V_ap_vld, SyncSig_V);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        write_frame(2);
        tick();
        SyncSig_V_ap_ack = 1;
        tick();
        SyncSig_V_ap_ack = 0;
        wr_ce = 1; wr_we = 1; wr_addr = 12'd7;
        #1;
        n_cmp++; if (bram_addr1 !== 13'h1007 || bram_ce1 !== 1'b1) begin
            n_fail++; $display("FAIL wr_bank1_write got a=%h ce=%b exp a=1007 ce=1", bram_addr1, bram_ce1);
        end
        tick();
        wr_ce = 0; wr_we = 0; wr_done = 1; rd_done = 1;
        tick();
        wr_done = 0; rd_done = 0;
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b0 || SyncSig_V !== 1'b1 || wr_ready !== 1'b1 || bram_addr1[AWIDTH] !== 1'b0) begin
            n_fail++; $display("FAIL same_edge got vld=%b sync=%b ready=%b wbank=%b exp 0 1 1 0", SyncSig_V_ap_vld, SyncSig_V, wr_ready, bram_addr1[AWIDTH]);
        end
        tick();
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b1 || SyncSig_V !== 1'b1) begin
            n_fail++; $display("FAIL same_edge_sync got vld=%b sync=%b exp 1 1", SyncSig_V_ap_vld, SyncSig_V);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        rd_done = 1; SyncSig_V_ap_ack = 1;
        tick();
        rd_done = 0; SyncSig_V_ap_ack = 0;
        tick();
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b0 || SyncSig_V !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ignore got vld=%b sync=%b ready=%b exp 0 0 1", SyncSig_V_ap_vld, SyncSig_V, wr_ready);
        end
        write_frame(1);
        tick();
        rd_ce = 1; rd_done = 1;
        #1;
        n_cmp++; if (bram_ce0 !== 1'b0) begin n_fail++; $display("FAIL sync_ce0 got %0b exp 0", bram_ce0); end
        tick();
        rd_ce = 0; rd_done = 0;
        n_cmp++; if (SyncSig_V_ap_vld !== 1'b1 || SyncSig_V !== 1'b0) begin
            n_fail++; $display("FAIL sync_rd_done_ignored got vld=%b sync=%b exp 1 0", SyncSig_V_ap_vld, SyncSig_V);
        end
    endtask

    task automatic test_reset_busy();
        SyncSig_V_ap_ack = 1;
        tick();
        SyncSig_V_ap_ack = 0;
        write_frame(2);
        wr_ce = 1;
        tick();
        tick();
        n_cmp++; if (wr_ready !== 1'b0 || blocked_cnt !== 8'd2) begin
            n_fail++; $display("FAIL pre_reset got ready=%b blocked=%0d exp 0 2", wr_ready, blocked_cnt);
        end
        rd_ce = 1;
        #2 ap_rst_n = 0;
        #1;
        n_cmp++; if (wr_ready !== 1'b1 || SyncSig_V_ap_vld !== 1'b0 || blocked_cnt !== 8'd0 || bram_ce0 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got ready=%b vld=%b blocked=%0d ce0=%b exp 1 0 0 0", wr_ready, SyncSig_V_ap_vld, blocked_cnt, bram_ce0);
        end
        idle_inputs();
        tick();
        ap_rst_n = 1;
        tick();
        write_frame(1);
        write_frame(1);
        wr_ce = 1;
        for (int c = 0; c < 255; c++) tick();
        n_cmp++; if (blocked_cnt !== 8'd255) begin n_fail++; $display("FAIL blocked_255 got %0d exp 255", blocked_cnt); end
        for (int c = 0; c < 45; c++) tick();
        wr_ce = 0;
        n_cmp++; if (blocked_cnt !== 8'd255) begin n_fail++; $display("FAIL blocked_saturate got %0d exp 255", blocked_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        ap_rst_n = 1;
        idle_inputs();
        test_reset();
        test_write_frame();
        test_hold_ack();
        test_both_full();
        test_same_cycle();
        test_ignored();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/act_pingpong_ctrl.md
ACT_PINGPONG_CTRL -- requirements
Module: act_pingpong_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, giving the per-bank word address width (bank = 2^AWIDTH words).
REQ-002 SHALL have parameter DWIDTH, default 16, giving the activation word width.
REQ-003 SHALL have one clock ap_clk (rising edge) and one asynchronous active-low reset ap_rst_n.
REQ-004 ap_clk  in  1  clock.
REQ-005 ap_rst_n  in  1  asynchronous reset, active low.
REQ-006 wr_addr  in  AWIDTH  writer word address within the current write bank.
REQ-007 wr_ce, wr_we  in  1 each  writer chip-enable and write-enable.
REQ-008 wr_d  in  DWIDTH  writer data.
REQ-009 wr_done  in  1  single-cycle pulse marking the last write of a frame.
REQ-010 wr_ready  out  1  high when the current write bank is empty.
REQ-011 rd_addr  in  AWIDTH  PE word address within the current read bank.
REQ-012 rd_ce  in  1  PE read enable.
REQ-013 rd_q  out  DWIDTH  read data, equal to bram_q0.
REQ-014 rd_done  in  1  single-cycle pulse, PE has finished consuming the frame.
REQ-015 SyncSig_V  out  1  bank index being handed to the PE.
REQ-016 SyncSig_V_ap_vld  out  1  frame-available strobe; SyncSig_V_ap_ack  in  1  PE acceptance.
REQ-017 bram_addr1  out  AWIDTH+1, bram_ce1, bram_we1  out  1, bram_d1  out  DWIDTH  BRAM write port.
REQ-018 bram_addr0  out  AWIDTH+1, bram_ce0  out  1, bram_q0  in  DWIDTH  BRAM read port (1-cycle latency).
REQ-019 blocked_cnt  out  8  saturating count of writer accesses rejected because wr_ready was low.

Function
REQ-020 SHALL hold state: full[1:0] per-bank flags, wr_bank and rd_bank pointers, reader FSM {IDLE, SYNC, BUSY}.
REQ-021 wr_ready SHALL equal !full[wr_bank], combinationally.
REQ-022 bram_addr1 = {wr_bank, wr_addr}; bram_d1 = wr_d; bram_ce1 = wr_ce & wr_ready; bram_we1 = wr_we & wr_ready.
REQ-023 wr_done while wr_ready SHALL set full[wr_bank] and toggle wr_bank at the same edge; wr_done while !wr_ready SHALL be ignored.
REQ-024 wr_ce while !wr_ready SHALL increment blocked_cnt by 1, saturating at 255.
REQ-025 IDLE -> SYNC when full[rd_bank]=1; otherwise remain in IDLE.
REQ-026 In SYNC: SyncSig_V_ap_vld=1 and SyncSig_V=rd_bank, both stable until the acknowledge; SyncSig_V_ap_ack=1 -> BUSY at that edge.
REQ-027 ap_vld SHALL be 0 in IDLE and BUSY; SyncSig_V SHALL equal rd_bank in all states.
REQ-028 bram_addr0 = {rd_bank, rd_addr}; bram_ce0 = rd_ce only in BUSY, 0 otherwise; rd_q = bram_q0.
REQ-029 In BUSY, rd_done SHALL clear full[rd_bank], toggle rd_bank and return to IDLE at that edge; rd_done outside BUSY SHALL be ignored.
REQ-030 wr_done and rd_done on the same edge SHALL both take effect; they always address different banks (the read bank is full, the write bank is empty).
REQ-031 SyncSig_V_ap_ack outside SYNC SHALL be ignored.
REQ-032 Minimum latency SHALL be: wr_done edge -> ap_vld high one cycle later (IDLE sees full, then enters SYNC).
REQ-033 With both banks full, wr_ready SHALL be 0 until rd_done; the writer then resumes in the freed bank.

Reset
REQ-034 Reset SHALL be asynchronous: full=00, wr_bank=0, rd_bank=0, FSM=IDLE, blocked_cnt=0; hence wr_ready=1, ap_vld=0, SyncSig_V=0, bram_ce0=0.
REQ-035 Reset asserted mid-frame SHALL discard all bank contents logically (flags cleared); BRAM data is not erased.

Verification
REQ-036 Reset, then write 4 words to bank 0, then wr_done -> bram_addr1 MSB=0 during writes; ap_vld=1 with SyncSig_V=0 one cycle after wr_done; wr_bank=1.
REQ-037 ap_vld held 5 cycles without ack -> SyncSig_V and ap_vld stable; ack -> BUSY; rd_ce with rd_addr=3 -> bram_addr0=0x003, bram_ce0=1.
REQ-038 Fill bank 0 and bank 1 without rd_done -> wr_ready=0; 3 wr_ce pulses -> bram_ce1=0, blocked_cnt=3; rd_done -> wr_ready=1 with wr_bank=0.
REQ-039 Same-cycle wr_done (bank 1) and rd_done (bank 0) -> full=10, rd_bank=1, FSM IDLE then SYNC with SyncSig_V=1.
REQ-040 rd_done and ack pulsed in IDLE, rd_ce in SYNC -> no state change, bram_ce0=0.
REQ-041 ap_rst_n asserted during BUSY with full=11 -> immediate wr_ready=1, ap_vld=0, blocked_cnt=0; 300 blocked writes then saturate blocked_cnt at 255.
